// File: rtl/dce_ce_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dce_ce_ctrl_if
// Purpose  : Bundles the request/status signals between a clock-gating
//            requester and the dce_ce_ctrl clock-enable controller.
// Signals  : req_on  - requester -> ctrl, level request for gated clock
//            idle    - requester -> ctrl, gated-domain quiescent flag (synced)
//            ce      - ctrl -> DCE CE pin, registered enable
//            ack     - ctrl -> requester, gated clock running and settled
//            busy    - ctrl -> requester, transition in progress
//            timeout - ctrl -> requester, one-cycle forced gate-off pulse
// Modports : master (requester side), slave (controller side)
// Revision : 1.0 - initial release
// ============================================================================
interface dce_ce_ctrl_if;
   logic req_on;
   logic idle;
   logic ce;
   logic ack;
   logic busy;
   logic timeout;

   modport master (
      output req_on,
      output idle,
      input  ce,
      input  ack,
      input  busy,
      input  timeout
   );

   modport slave (
      input  req_on,
      input  idle,
      output ce,
      output ack,
      output busy,
      output timeout
   );
endinterface : dce_ce_ctrl_if
`default_nettype wire

// File: rtl/dce_ce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dce_ce_ctrl
// Purpose  : Sequences the CE pin of a downstream clock gate (DCE). Power-up
//            waits ON_DLY cycles before acknowledging; power-down waits for
//            the gated domain to go idle (or IDLE_TO cycles, then forces it)
//            and then holds CE low for at least OFF_DLY+1 cycles.
// Ports    : clk - free-running clock (also drives DCE clkin)
//            rst - synchronous active-high reset
//            bus - dce_ce_ctrl_if.slave (req_on, idle in; ce, ack, busy,
//                  timeout out, all outputs registered)
// Params   : ON_DLY  (1..255)   cycles of ce high before ack
//            OFF_DLY (1..255)   minimum ce-low hold after gating off
//            IDLE_TO (1..65535) drain cycles before a forced gate-off
// Revision : 1.0 - initial release
// ============================================================================
module dce_ce_ctrl #(
   parameter int ON_DLY  = 4,
   parameter int OFF_DLY = 4,
   parameter int IDLE_TO = 1024
) (
   input  wire           clk,
   input  wire           rst,
   dce_ce_ctrl_if.slave  bus
);

   localparam int MAX_A   = (ON_DLY > OFF_DLY) ? ON_DLY : OFF_DLY;
   localparam int MAX_DLY = (MAX_A > IDLE_TO) ? MAX_A : IDLE_TO;
   localparam int CNT_W   = $clog2(MAX_DLY + 1);

   localparam logic [CNT_W-1:0] ON_LD   = CNT_W'(ON_DLY);
   localparam logic [CNT_W-1:0] OFF_LD  = CNT_W'(OFF_DLY);
   localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_TO);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   localparam logic [2:0] S_OFF      = 3'd0;
   localparam logic [2:0] S_PRE_ON   = 3'd1;
   localparam logic [2:0] S_ON       = 3'd2;
   localparam logic [2:0] S_DRAIN    = 3'd3;
   localparam logic [2:0] S_POST_OFF = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ce_q, ce_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;
   logic             tmo_q, tmo_d;

   // Next-state logic. A count of 1 (or 0, defensively) ends a timed state,
   // so the counter never has to pass below zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      case (state_q)
         S_OFF: begin
            if (bus.req_on) begin
               state_d = S_PRE_ON;
               cnt_d   = ON_LD;
            end
         end
         S_PRE_ON: begin
            // Runs to completion; a dropped request is handled from ON.
            if (cnt_q <= ONE) begin
               state_d = S_ON;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         S_ON: begin
            if (!bus.req_on) begin
               state_d = S_DRAIN;
               cnt_d   = IDLE_LD;
            end
         end
         S_DRAIN: begin
            // Renewed request wins over idle and over an expiring count.
            if (bus.req_on) begin
               state_d = S_ON;
               cnt_d   = '0;
            end else if (bus.idle) begin
               state_d = S_POST_OFF;
               cnt_d   = OFF_LD;
            end else if (cnt_q <= ONE) begin
               state_d = S_POST_OFF;
               cnt_d   = OFF_LD;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         S_POST_OFF: begin
            // req_on deliberately ignored until OFF is reached.
            if (cnt_q <= ONE) begin
               state_d = S_OFF;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         default: begin
            state_d = S_OFF;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so ce has no
   // combinational path from any input.
   always_comb begin
      ce_d   = (state_d == S_PRE_ON) || (state_d == S_ON) || (state_d == S_DRAIN);
      ack_d  = (state_d == S_ON);
      busy_d = (state_d == S_PRE_ON) || (state_d == S_DRAIN) || (state_d == S_POST_OFF);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         ce_q    <= 1'b0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ce_q    <= ce_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.ce      = ce_q;
   assign bus.ack     = ack_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = tmo_q;

endmodule : dce_ce_ctrl
`default_nettype wire

// File: tb/tb_dce_ce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dce_ce_ctrl
// Purpose  : Directed scoreboard bench for dce_ce_ctrl (ON_DLY=4, OFF_DLY=4,
//            IDLE_TO=16). Stimulus pushes the hand-derived {ce,ack,busy,
//            timeout} expected after each clock edge; a monitor pops and
//            compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dce_ce_ctrl;

   // {ce, ack, busy, timeout}
   localparam logic [3:0] E_OFF = 4'b0000;
   localparam logic [3:0] E_PRE = 4'b1010;
   localparam logic [3:0] E_ON  = 4'b1100;
   localparam logic [3:0] E_DR  = 4'b1010;
   localparam logic [3:0] E_PO  = 4'b0010;
   localparam logic [3:0] E_POT = 4'b0011;

   typedef struct {
      logic [3:0] val;
      string      tag;
   } exp_t;

   logic  clk;
   logic  rst;
   exp_t  exp_q[$];
   string phase;
   int    n_cmp;
   int    n_fail;

   dce_ce_ctrl_if bus();

   dce_ce_ctrl #(
      .ON_DLY  (4),
      .OFF_DLY (4),
      .IDLE_TO (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: apply inputs before the edge, expect val after it.
   task automatic cyc(input logic r, input logic req, input logic idl, input logic [3:0] val);
      exp_t e;
      @(negedge clk);
      rst        = r;
      bus.req_on = req;
      bus.idle   = idl;
      @(posedge clk);
      #1;
      e.val = val;
      e.tag = phase;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n, input logic r, input logic req, input logic idl,
                      input logic [3:0] val);
      for (int i = 0; i < n; i++) cyc(r, req, idl, val);
   endtask

   // Monitor / checker
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         logic [3:0] got;
         e   = exp_q.pop_front();
         got = {bus.ce, bus.ack, bus.busy, bus.timeout};
         n_cmp++;
         if (got !== e.val) begin
            n_fail++;
            $display("FAIL %s @%0t: {ce,ack,busy,timeout} got %b expected %b",
                     e.tag, $time, got, e.val);
         end
      end
   end

   initial begin
      n_cmp      = 0;
      n_fail     = 0;
      rst        = 1'b1;
      bus.req_on = 1'b0;
      bus.idle   = 1'b0;

      phase = "reset";
      run(3, 1, 0, 0, E_OFF);
      phase = "off_idle";
      run(5, 0, 0, 0, E_OFF);

      // Power-up: ce on the sampling edge, ack 4 edges later
      phase = "power_up";
      run(4, 0, 1, 0, E_PRE);
      run(5, 0, 1, 0, E_ON);

      // Drop request with idle=1: DRAIN one cycle, POST_OFF 4, then OFF
      phase = "idle_off";
      cyc(0, 0, 1, E_DR);
      run(4, 0, 0, 1, E_PO);
      run(3, 0, 0, 0, E_OFF);

      phase = "power_up2";
      run(4, 0, 1, 0, E_PRE);
      run(2, 0, 1, 0, E_ON);

      // Forced gate-off: 16 DRAIN cycles, then single timeout pulse
      phase = "timeout";
      run(16, 0, 0, 0, E_DR);
      cyc(0, 0, 0, E_POT);
      run(3, 0, 0, 0, E_PO);
      run(2, 0, 0, 0, E_OFF);

      phase = "power_up3";
      run(4, 0, 1, 0, E_PRE);
      run(2, 0, 1, 0, E_ON);

      // req_on and idle together in DRAIN: back to ON, ce never drops
      phase = "drain_reraise";
      run(4, 0, 0, 0, E_DR);
      cyc(0, 1, 1, E_ON);
      run(3, 0, 1, 0, E_ON);

      // req_on wins over an expiring count on the last DRAIN cycle
      phase = "drain_req_vs_to";
      run(16, 0, 0, 0, E_DR);
      cyc(0, 1, 0, E_ON);
      run(2, 0, 1, 0, E_ON);

      // Re-request during POST_OFF is ignored until OFF
      phase = "postoff_req";
      cyc(0, 0, 1, E_DR);
      cyc(0, 0, 1, E_PO);
      run(3, 0, 1, 0, E_PO);
      cyc(0, 1, 0, E_OFF);
      run(4, 0, 1, 0, E_PRE);
      run(2, 0, 1, 0, E_ON);

      // Reset in ON with req held: ce drops, returns the next edge
      phase = "rst_in_on";
      cyc(1, 1, 0, E_OFF);
      run(4, 0, 1, 0, E_PRE);
      run(1, 0, 1, 0, E_ON);

      // Reset in DRAIN: no drain completion, no timeout pulse
      phase = "rst_in_drain";
      run(3, 0, 0, 0, E_DR);
      cyc(1, 0, 0, E_OFF);
      run(3, 0, 0, 0, E_OFF);

      // Request dropped during PRE_ON still completes into ON
      phase = "pre_on_drop";
      cyc(0, 1, 0, E_PRE);
      run(3, 0, 0, 0, E_PRE);
      cyc(0, 0, 0, E_ON);
      cyc(0, 0, 1, E_DR);
      run(4, 0, 0, 1, E_PO);
      cyc(0, 0, 0, E_OFF);

      // Let the monitor drain the queue, bounded
      begin
         int waited;
         waited = 0;
         while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
         end
         if (exp_q.size() > 0) begin
            n_fail += exp_q.size();
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_dce_ce_ctrl
`default_nettype wire
